bitonic_sort_pipe: RTL and testbench
====================================

Name: bitonic_sort_pipe

Overview:
- Fully pipelined bitonic sorting network for NUM_ELEMS unsigned keys of DATA_WIDTH bits.
- Accepts one vector per cycle, with a per-vector ascending/descending mode.
- Emits the sorted vector after a fixed latency, with valid/ready backpressure on both sides.
- Successor to the single-node stage: becomes the sorting core behind the stream front-end.

Parameters:
- DATA_WIDTH, 8, bits per key (unsigned).
- NUM_ELEMS, 8, keys per vector; power of two, at least 2.
- CNT_WIDTH, 16, width of the completed-sort counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; asserted when 0.
- in_valid  input  1  data_in and descending are valid this cycle.
- in_ready  output  1  block accepts a vector this cycle.
- descending  input  1  sampled with the vector; 0 = ascending, 1 = descending.
- data_in  input  NUM_ELEMS*DATA_WIDTH  element i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- out_valid  output  1  data_out holds a sorted vector.
- out_ready  input  1  downstream accepts data_out.
- data_out  output  NUM_ELEMS*DATA_WIDTH  sorted vector, same packing as data_in; zero when out_valid=0.
- busy  output  1  any pipeline stage holds a valid vector.
- sort_count  output  CNT_WIDTH  number of vectors delivered (out_valid && out_ready); saturates at all-ones.

Behaviour:
- S = log2(NUM_ELEMS). Network layers are the (k, j) pairs, with k = 2, 4, ..., NUM_ELEMS and, for each k, j = k/2 down to 1.
  - Layer count L = S*(S+1)/2: N=8 gives 6, N=4 gives 3, N=2 gives 1.
- Each layer is one register stage holding keys, a valid bit and a mode bit. Output comes from the last stage; latency is L cycles from acceptance to out_valid with no stalls.
- Compare-exchange in layer (k, j): for each i with (i & j) == 0, partner p = i | j.
  - up = ((i & k) == 0) XOR descending.
  - If up, the slot i gets min and slot p gets max; otherwise swapped.
  - Comparison is unsigned. Equal keys are not swapped.
- Final ordering: ascending mode puts the smallest key at element 0; descending mode puts the largest key at element 0.
- Flow control: the pipeline is one global-enable shift register.
  - advance = !out_valid || out_ready.
  - in_ready = advance.
  - Vector accepted when in_valid && in_ready.
  - When advance = 0, every stage holds, including data_out.
  - Bubbles (in_valid = 0 while advancing) propagate as invalid stages.
  - No bubble-collapsing.
- Throughput: one vector per cycle while out_ready stays 1.
- Mode bit travels with its vector. Mixed modes in flight do not interact.
- sort_count increments on every out_valid && out_ready cycle and holds at 2^CNT_WIDTH-1.
- busy = OR of all stage valid bits.
- Reset (reset=0, any time, including mid-stream):
  - All valid bits, data and mode bits, and sort_count clear immediately.
  - out_valid=0, data_out=0, busy=0, sort_count=0.
  - in_ready=1 (advance is true while out_valid=0).
  - In-flight vectors are discarded, not flushed out.
- First acceptance is possible on the first rising edge after reset deasserts.
- Simultaneous output handshake and input acceptance in the same cycle are legal; both occur.
- Stalling under out_ready=0 never drops or duplicates a vector. A vector presented with in_ready=0 is not accepted; the source holds it.

Decomposition:
- Shared package bitonic_pkg:
  - function clog2;
  - function num_layers(n) returning S*(S+1)/2;
  - functions layer_k(idx) and layer_j(idx) mapping a flat layer index to (k, j);
  - a localparam-style typedef for a key.
- Sub-module bitonic_cas: parameter DATA_WIDTH.
  - Inputs a, b, up. Outputs lo_or_hi pair.
  - Purely combinational.
  - Instantiated NUM_ELEMS/2 times per layer via generate.
- Stage registers live in bitonic_sort_pipe.

Test Plan:
- Reset then single vector, N=8, W=8, ascending. data_in elements 0..7 = {5,3,8,1,7,2,6,4} → after 6 cycles out_valid=1, data_out = {1,2,3,4,5,6,7,8}, sort_count=1.
- Same data, descending=1 → {8,7,6,5,4,3,2,1}. Duplicates {9,9,0,0,255,1,1,9} ascending → {0,0,1,1,9,9,9,255}.
- Back-to-back, out_ready=1: 10 random vectors on consecutive cycles with alternating modes → outputs on 10 consecutive cycles, in order, each matching a reference sort. sort_count=10.
- Backpressure: pipeline full, hold out_ready=0 for 4 cycles → in_ready=0 and data_out stable throughout. Release → all vectors emerge in order with no loss or duplication.
- Reset mid-stream: assert reset=0 with 3 vectors in flight → out_valid, busy and sort_count are 0 immediately. After release, no stale vector ever appears.
- Saturation and edge keys: CNT_WIDTH=2, deliver 5 vectors → sort_count stops at 3. Keys {0,255,...} are sorted correctly. An N=2 instance has latency 1.

Source files
------------

// File: rtl/bitonic_pkg.sv
// Shared helpers for the bitonic sorting network: layer enumeration and key type.
// Layers are numbered in the order the data passes through them.
package bitonic_pkg;

    localparam int KEY_WIDTH = 8;
    typedef logic [KEY_WIDTH-1:0] key_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int num_layers(input int n);
        int s;
        s = clog2(n);
        return (s * (s + 1)) / 2;
    endfunction

    // Flat layer index -> merge size k (k = 2, 4, ..., N).
    function automatic int layer_k(input int idx);
        int cnt;
        int res;
        cnt = 0;
        res = 2;
        for (int s = 1; s <= 16; s++) begin
            for (int t = s; t >= 1; t--) begin
                if (cnt == idx) begin
                    res = 1 << s;
                end
                cnt = cnt + 1;
            end
        end
        return res;
    endfunction

    // Flat layer index -> partner distance j (k/2 down to 1).
    function automatic int layer_j(input int idx);
        int cnt;
        int res;
        cnt = 0;
        res = 1;
        for (int s = 1; s <= 16; s++) begin
            for (int t = s; t >= 1; t--) begin
                if (cnt == idx) begin
                    res = 1 << (t - 1);
                end
                cnt = cnt + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bitonic_cas.sv
// Combinational compare-exchange node. With up=1 out_a takes the smaller key,
// otherwise the larger; equal keys pass straight through.
module bitonic_cas #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  up,
    output logic [DATA_WIDTH-1:0] out_a,
    output logic [DATA_WIDTH-1:0] out_b
);

    logic swap;

    assign swap  = up ? (a > b) : (a < b);
    assign out_a = swap ? b : a;
    assign out_b = swap ? a : b;

endmodule

// File: rtl/bitonic_sort_pipe.sv
// Fully pipelined bitonic sorter: one register stage per network layer, all
// stages advancing together under a single global enable.
module bitonic_sort_pipe
    import bitonic_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_ELEMS  = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            descending,
    input  logic [NUM_ELEMS*DATA_WIDTH-1:0] data_in,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_ELEMS*DATA_WIDTH-1:0] data_out,
    output logic                            busy,
    output logic [CNT_WIDTH-1:0]            sort_count
);

    localparam int L = num_layers(NUM_ELEMS);

    logic [DATA_WIDTH-1:0] key_reg [L][NUM_ELEMS];
    logic [L-1:0]          valid_reg;
    logic [L-1:0]          desc_reg;
    logic [CNT_WIDTH-1:0]  count_reg;

    logic [DATA_WIDTH-1:0] lay_in  [L][NUM_ELEMS];
    logic [DATA_WIDTH-1:0] lay_out [L][NUM_ELEMS];
    logic [L-1:0]          lay_valid;
    logic [L-1:0]          lay_desc;
    logic                  advance;

    assign out_valid = valid_reg[L-1];
    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;
    assign busy      = |valid_reg;
    assign sort_count = count_reg;

    generate
        for (genvar gi = 0; gi < L; gi++) begin : g_layer
            localparam int K = layer_k(gi);
            localparam int J = layer_j(gi);

            if (gi == 0) begin : g_first
                assign lay_valid[gi] = in_valid;
                assign lay_desc[gi]  = descending;
                for (genvar ge = 0; ge < NUM_ELEMS; ge++) begin : g_elem
                    assign lay_in[gi][ge] = data_in[ge*DATA_WIDTH +: DATA_WIDTH];
                end
            end else begin : g_rest
                assign lay_valid[gi] = valid_reg[gi-1];
                assign lay_desc[gi]  = desc_reg[gi-1];
                for (genvar ge = 0; ge < NUM_ELEMS; ge++) begin : g_elem
                    assign lay_in[gi][ge] = key_reg[gi-1][ge];
                end
            end

            // Pair q enumerates the indices i with (i & j) == 0 in increasing order.
            for (genvar gj = 0; gj < NUM_ELEMS / 2; gj++) begin : g_pair
                localparam int   I   = (gj / J) * 2 * J + (gj % J);
                localparam int   P   = I + J;
                localparam logic ASC = ((I & K) == 0);

                bitonic_cas #(
                    .DATA_WIDTH(DATA_WIDTH)
                ) u_cas (
                    .a    (lay_in[gi][I]),
                    .b    (lay_in[gi][P]),
                    .up   (ASC ^ lay_desc[gi]),
                    .out_a(lay_out[gi][I]),
                    .out_b(lay_out[gi][P])
                );
            end
        end

        for (genvar ge = 0; ge < NUM_ELEMS; ge++) begin : g_out
            assign data_out[ge*DATA_WIDTH +: DATA_WIDTH] =
                out_valid ? key_reg[L-1][ge] : '0;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_reg <= '0;
            desc_reg  <= '0;
            key_reg   <= '{default: '0};
        end else if (advance) begin
            valid_reg <= lay_valid;
            desc_reg  <= lay_desc;
            key_reg   <= lay_out;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (out_valid && out_ready && (count_reg != '1)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: tb/tb_bitonic_sort_pipe.sv
// Randomised and directed bench for bitonic_sort_pipe with a queue-based sorting
// reference; also exercises a 2-bit-counter instance and a two-key instance.
module tb_bitonic_sort_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        in_valid, descending, out_ready;
    logic [63:0] data_in;
    logic        in_ready, out_valid, busy;
    logic [63:0] data_out;
    logic [15:0] sort_count;

    logic        s_in_ready, s_out_valid, s_busy;
    logic [63:0] s_data_out;
    logic [1:0]  s_count;

    logic        n2_in_valid, n2_desc, n2_out_ready;
    logic [15:0] n2_data_in;
    logic        n2_in_ready, n2_out_valid, n2_busy;
    logic [15:0] n2_data_out;
    logic [15:0] n2_count;

    int tests = 0;
    int fails = 0;
    logic [63:0] exp_q[$];
    int model_cnt = 0;

    bitonic_sort_pipe #(.DATA_WIDTH(8), .NUM_ELEMS(8), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .descending(descending), .data_in(data_in), .out_valid(out_valid),
        .out_ready(out_ready), .data_out(data_out), .busy(busy), .sort_count(sort_count)
    );

    bitonic_sort_pipe #(.DATA_WIDTH(8), .NUM_ELEMS(8), .CNT_WIDTH(2)) dut_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
        .descending(descending), .data_in(data_in), .out_valid(s_out_valid),
        .out_ready(out_ready), .data_out(s_data_out), .busy(s_busy), .sort_count(s_count)
    );

    bitonic_sort_pipe #(.DATA_WIDTH(8), .NUM_ELEMS(2), .CNT_WIDTH(16)) dut_n2 (
        .clk(clk), .reset(reset), .in_valid(n2_in_valid), .in_ready(n2_in_ready),
        .descending(n2_desc), .data_in(n2_data_in), .out_valid(n2_out_valid),
        .out_ready(n2_out_ready), .data_out(n2_data_out), .busy(n2_busy), .sort_count(n2_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pk(input logic [7:0] e0, e1, e2, e3, e4, e5, e6, e7);
        return {e7, e6, e5, e4, e3, e2, e1, e0};
    endfunction

    // Reference: unpack, sort as plain integers, repack.
    function automatic logic [63:0] ref_sort(input logic [63:0] v, input logic d);
        int q[$];
        logic [63:0] r;
        for (int i = 0; i < 8; i++) q.push_back(int'(v[i*8 +: 8]));
        if (d) q.rsort();
        else   q.sort();
        r = '0;
        for (int i = 0; i < 8; i++) r[i*8 +: 8] = q[i][7:0];
        return r;
    endfunction

    function automatic logic [63:0] rand_vec();
        return {$urandom, $urandom};
    endfunction

    // Scoreboard: every cycle, outputs against the queue of accepted, undelivered vectors.
    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
            model_cnt = 0;
            check("rst_out_valid", out_valid, 0);
            check("rst_busy", busy, 0);
        end else begin
            check("in_ready", in_ready, !out_valid || out_ready);
            check("busy", busy, exp_q.size() != 0);
            check("count", sort_count, (model_cnt > 65535) ? 65535 : model_cnt);
            check("sat_count", s_count, (model_cnt > 3) ? 3 : model_cnt);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    check("data_out", data_out, exp_q[0]);
                    check("sat_data_out", s_data_out, exp_q[0]);
                end
            end else begin
                check("data_out_zero", data_out, 0);
            end
            if (out_valid && out_ready && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                model_cnt++;
            end
            if (in_valid && in_ready) exp_q.push_back(ref_sort(data_in, descending));
        end
    end

    // Present a vector and hold it until accepted; returns at acceptance edge + 1.
    task automatic send(input logic [63:0] v, input logic d);
        in_valid   = 1'b1;
        data_in    = v;
        descending = d;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        check("accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic directed(input string name, input logic [63:0] v, input logic d,
                            input logic [63:0] exp);
        int lat;
        logic [15:0] c0;
        c0 = sort_count;
        send(v, d);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, "_latency"}, lat, 6);
        check(name, data_out, exp);
        @(posedge clk);
        #1;
        check({name, "_count"}, sort_count, c0 + 16'd1);
    endtask

    task automatic drain();
        for (int t = 0; t < 40 && busy; t++) begin
            @(posedge clk);
            #1;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] snap, v7;
        logic [15:0] c0;
        int run;
        logic [15:0] n2_in [3];
        logic        n2_d  [3];
        logic [15:0] n2_exp[3];

        reset = 1'b0; in_valid = 1'b0; descending = 1'b0; data_in = '0; out_ready = 1'b1;
        n2_in_valid = 1'b0; n2_desc = 1'b0; n2_data_in = '0; n2_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_data_out", data_out, 0);
        check("reset_busy", busy, 0);
        check("reset_count", sort_count, 0);
        check("reset_in_ready", in_ready, 1);
        check("reset_n2_out_valid", n2_out_valid, 0);
        reset = 1'b1;

        // Pin the reference model with hand-sorted literals.
        check("model_asc", ref_sort(pk(5,3,8,1,7,2,6,4), 1'b0), pk(1,2,3,4,5,6,7,8));
        check("model_desc", ref_sort(pk(5,3,8,1,7,2,6,4), 1'b1), pk(8,7,6,5,4,3,2,1));

        directed("asc", pk(5,3,8,1,7,2,6,4), 1'b0, pk(1,2,3,4,5,6,7,8));
        directed("desc", pk(5,3,8,1,7,2,6,4), 1'b1, pk(8,7,6,5,4,3,2,1));
        directed("dup", pk(9,9,0,0,255,1,1,9), 1'b0, pk(0,0,1,1,9,9,9,255));
        directed("edge", pk(255,0,128,0,255,1,254,0), 1'b0, pk(0,0,0,1,128,254,255,255));
        directed("edge_desc", pk(0,255,0,255,0,255,0,255), 1'b1, pk(255,255,255,255,0,0,0,0));

        // Back-to-back, alternating modes.
        c0 = sort_count;
        run = 0;
        fork
            begin
                for (int i = 0; i < 10; i++) send(rand_vec(), i[0]);
            end
            begin
                for (int t = 0; t < 30 && !out_valid; t++) @(negedge clk);
                while (out_valid && run < 20) begin
                    run++;
                    @(negedge clk);
                end
            end
        join
        check("b2b_consecutive", run, 10);
        drain();
        check("b2b_count", sort_count, c0 + 16'd10);

        // Backpressure: fill the pipe, stall, release.
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(rand_vec(), $urandom_range(0, 1));
        v7 = rand_vec();
        in_valid = 1'b1; data_in = v7; descending = 1'b1;
        @(negedge clk);
        snap = data_out;
        for (int i = 0; i < 4; i++) begin
            check("stall_in_ready", in_ready, 0);
            check("stall_out_valid", out_valid, 1);
            check("stall_data_stable", data_out, snap);
            @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(v7, 1'b1);
        drain();

        // Reset with three vectors in flight.
        for (int i = 0; i < 3; i++) send(rand_vec(), i[0]);
        reset = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_count", sort_count, 0);
        check("midrst_data_out", data_out, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        check("post_rst_busy", busy, 0);
        check("post_rst_out_valid", out_valid, 0);

        // Counter saturation on the 2-bit instance.
        for (int i = 0; i < 5; i++) send(rand_vec(), $urandom_range(0, 1));
        drain();
        check("sat_final", s_count, 3);
        check("sat_main_count", sort_count, 5);

        // Two-key instance: one-cycle latency.
        n2_in[0] = {8'd7, 8'd200}; n2_d[0] = 1'b0; n2_exp[0] = {8'd200, 8'd7};
        n2_in[1] = {8'd9, 8'd3};   n2_d[1] = 1'b1; n2_exp[1] = {8'd3, 8'd9};
        n2_in[2] = {8'd5, 8'd5};   n2_d[2] = 1'b0; n2_exp[2] = {8'd5, 8'd5};
        for (int i = 0; i < 3; i++) begin
            n2_in_valid = 1'b1; n2_data_in = n2_in[i]; n2_desc = n2_d[i];
            @(posedge clk); #1;
            n2_in_valid = 1'b0;
            check("n2_latency1_valid", n2_out_valid, 1);
            check("n2_data", n2_data_out, n2_exp[i]);
            @(posedge clk); #1;
        end
        check("n2_count", n2_count, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
